// File: rtl/axi_crossbar_rresp_if.sv
// R-channel bundle shared by the merged internal stream and the upstream port.
// master drives payload/valid, slave returns ready.
interface axi_crossbar_rresp_if #(
  parameter int ID_WIDTH    = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int RUSER_WIDTH = 1
);
  logic [ID_WIDTH-1:0]    rid;
  logic [DATA_WIDTH-1:0]  rdata;
  logic [1:0]             rresp;
  logic                   rlast;
  logic [RUSER_WIDTH-1:0] ruser;
  logic                   rvalid;
  logic                   rready;

  modport master (output rid, rdata, rresp, rlast, ruser, rvalid, input rready);
  modport slave  (input rid, rdata, rresp, rlast, ruser, rvalid, output rready);
endinterface

// File: rtl/axi_crossbar_rresp.sv
// Read-response return stage: merges arbitrated R beats with locally generated
// DECERR bursts, drives upstream R through a skid stage, and reports completions.
module axi_crossbar_rresp #(
  parameter int ID_WIDTH     = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int RUSER_ENABLE = 0,
  parameter int RUSER_WIDTH  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ID_WIDTH-1:0] s_rc_id,
  input  logic [7:0]          s_rc_len,
  input  logic                s_rc_decerr,
  input  logic                s_rc_valid,
  output logic                s_rc_ready,
  axi_crossbar_rresp_if.slave  s_int,
  axi_crossbar_rresp_if.master s_axi,
  output logic [ID_WIDTH-1:0] m_cpl_id,
  output logic                m_cpl_valid
);

  typedef struct packed {
    logic [ID_WIDTH-1:0]    id;
    logic [DATA_WIDTH-1:0]  data;
    logic [1:0]             resp;
    logic                   last;
    logic [RUSER_WIDTH-1:0] user;
  } beat_t;

  typedef enum logic [1:0] {IDLE, PASS, DECERR} state_t;

  state_t              state, state_nxt;
  logic [ID_WIDTH-1:0] err_id, err_id_nxt;
  logic [7:0]          cnt, cnt_nxt;

  beat_t out_q, skid_q, in_beat, int_beat;
  logic  out_vld, skid_vld, in_ready, in_vld;

  // Skid register holds at most one beat, so space exists whenever it is empty.
  assign in_ready = ~skid_vld;

  always_comb begin
    int_beat.id   = s_int.rid;
    int_beat.data = s_int.rdata;
    int_beat.resp = s_int.rresp;
    int_beat.last = s_int.rlast;
    int_beat.user = (RUSER_ENABLE != 0) ? s_int.ruser : '0;
  end

  always_comb begin
    state_nxt    = state;
    err_id_nxt   = err_id;
    cnt_nxt      = cnt;
    s_rc_ready   = 1'b0;
    s_int.rready = 1'b0;
    in_vld       = 1'b0;
    in_beat      = int_beat;
    case (state)
      IDLE: begin
        s_rc_ready = 1'b1;
        if (s_rc_valid && s_rc_decerr) begin
          err_id_nxt = s_rc_id;
          cnt_nxt    = s_rc_len;
          state_nxt  = DECERR;
        end else begin
          s_int.rready = in_ready;
          in_vld       = s_int.rvalid && in_ready;
          if (in_vld && !s_int.rlast) state_nxt = PASS;
        end
      end
      PASS: begin
        s_int.rready = in_ready;
        in_vld       = s_int.rvalid && in_ready;
        if (in_vld && s_int.rlast) state_nxt = IDLE;
      end
      DECERR: begin
        in_vld  = in_ready;
        in_beat = '{id: err_id, data: '0, resp: 2'b11, last: (cnt == 8'd0), user: '0};
        if (in_ready) begin
          // cnt counts remaining beats after this one, so len=255 gives 256 beats
          if (cnt == 8'd0) state_nxt = IDLE;
          else             cnt_nxt   = cnt - 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      s_rc_ready   = 1'b0;
      s_int.rready = 1'b0;
      in_vld       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    err_id <= err_id_nxt;
    cnt    <= cnt_nxt;
  end

  // Output register refills from skid first so beat order is preserved.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
    end else if (!out_vld || s_axi.rready) begin
      if (skid_vld) begin
        out_q    <= skid_q;
        skid_vld <= 1'b0;
      end else begin
        out_vld <= in_vld;
        if (in_vld) out_q <= in_beat;
      end
    end else if (in_vld) begin
      skid_q   <= in_beat;
      skid_vld <= 1'b1;
    end
  end

  assign s_axi.rid    = out_q.id;
  assign s_axi.rdata  = out_q.data;
  assign s_axi.rresp  = out_q.resp;
  assign s_axi.rlast  = out_q.last;
  assign s_axi.ruser  = out_q.user;
  assign s_axi.rvalid = out_vld;

  assign m_cpl_valid = out_vld && s_axi.rready && out_q.last && !rst;
  assign m_cpl_id    = out_q.id;

endmodule
